// File: rtl/data_memory_responder.sv
// data_memory_responder: data-memory port responder decoding RAM, an unmapped hole and an IO page (timer, wake unit, GPIO).
module data_memory_responder #(
  parameter int ADDR_SIZE      = 18,
  parameter int WORD_SIZE      = 18,
  parameter int RAM_WORDS_LOG2 = 10,
  parameter int GPIO_WIDTH     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_SIZE-1:0]  memory_addr,
  input  logic                  memory_write_enable,
  input  logic [WORD_SIZE-1:0]  memory_in,
  output logic [WORD_SIZE-1:0]  memory_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  wake
);
  localparam logic [WORD_SIZE-1:0] ONE = 1;
  logic                      io_sel, ram_sel, io_we, ram_we, match, ram_sel_q, enable, pending;
  logic [7:0]                off;
  logic [WORD_SIZE-1:0]      ram [2**RAM_WORDS_LOG2];
  logic [WORD_SIZE-1:0]      ram_q, io_rd, io_q, count, compare;
  logic [GPIO_WIDTH-1:0]     sync1, sync2;
  logic [RAM_WORDS_LOG2-1:0] idx;
  assign io_sel  = &memory_addr[ADDR_SIZE-1:8];
  assign ram_sel = memory_addr[ADDR_SIZE-1:RAM_WORDS_LOG2] == '0;
  assign off     = memory_addr[7:0];
  assign idx     = memory_addr[RAM_WORDS_LOG2-1:0];
  assign io_we   = memory_write_enable && io_sel;
  assign ram_we  = memory_write_enable && ram_sel;
  assign match   = enable && (count == compare);
  always_comb begin
    io_rd = !io_sel        ? '0 :
            off == 8'h00   ? count :
            off == 8'h01   ? compare :
            off == 8'h02   ? {{(WORD_SIZE-2){1'b0}}, pending, enable} :
            off == 8'h03   ? WORD_SIZE'(gpio_out) :
            off == 8'h04   ? WORD_SIZE'(sync2) : '0;
  end
  // RAM and its read register carry no reset so contents survive it; read-first via non-blocking order
  always_ff @(posedge clock) begin
    if (ram_we) ram[idx] <= memory_in;
    ram_q <= ram[idx];
  end
  assign memory_out = ram_sel_q ? ram_q : io_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_sel_q <= 1'b0;
      io_q      <= '0;
      count     <= '0;
      compare   <= '0;
      enable    <= 1'b0;
      pending   <= 1'b0;
      wake      <= 1'b0;
      gpio_out  <= '0;
      sync1     <= '0;
      sync2     <= '0;
    end else begin
      ram_sel_q <= ram_sel;
      io_q      <= io_rd;
      count     <= (io_we && off == 8'h00) ? memory_in : count + ONE;
      compare   <= (io_we && off == 8'h01) ? memory_in : compare;
      enable    <= (io_we && off == 8'h02) ? memory_in[0] : enable;
      pending   <= match ? 1'b1 : (io_we && off == 8'h02 && memory_in[1]) ? 1'b0 : pending;
      wake      <= match;
      gpio_out  <= (io_we && off == 8'h03) ? memory_in[GPIO_WIDTH-1:0] : gpio_out;
      sync1     <= gpio_in;
      sync2     <= sync1;
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed scoreboard bench for the data-memory responder.
module tb_data_memory_responder;
  localparam logic [17:0] IO = 18'h3FF00;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] memory_addr = '0;
  logic        memory_write_enable = 1'b0;
  logic [17:0] memory_in = '0;
  logic [17:0] memory_out;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        wake;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];
  string       tag_q[$];

  data_memory_responder dut (
    .clock(clock), .reset(reset), .memory_addr(memory_addr),
    .memory_write_enable(memory_write_enable), .memory_in(memory_in),
    .memory_out(memory_out), .gpio_in(gpio_in), .gpio_out(gpio_out), .wake(wake)
  );

  always #5 clock = ~clock;

  task automatic chk_bit(input string tag, input logic obs, input logic e);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic chk_word(input string tag, input logic [17:0] obs, input logic [17:0] e);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // One access per cycle; a checked read pushes its expectation and pops it once the edge has produced data.
  task automatic acc(input logic [17:0] a, input logic w, input logic [17:0] d,
                     input bit chk, input logic [17:0] e, input int wexp, input string tag);
    logic [17:0] ev;
    string       et;
    memory_addr = a;
    memory_write_enable = w;
    memory_in = d;
    if (chk) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clock);
    #1;
    memory_write_enable = 1'b0;
    if (chk) begin
      ev = exp_q.pop_front();
      et = tag_q.pop_front();
      chk_word(et, memory_out, ev);
    end
    if (wexp >= 0) chk_bit({tag, "_wake"}, wake, wexp[0]);
  endtask

  task automatic wr(input logic [17:0] a, input logic [17:0] d, input int wexp = -1);
    acc(a, 1'b1, d, 1'b0, '0, wexp, "wr");
  endtask

  task automatic rd(input logic [17:0] a, input logic [17:0] e, input string tag, input int wexp = -1);
    acc(a, 1'b0, '0, 1'b1, e, wexp, tag);
  endtask

  task automatic idle(input int wexp, input string tag);
    acc(18'h00100, 1'b0, '0, 1'b0, '0, wexp, tag);
  endtask

  initial begin
    #2;
    chk_word("rst_memory_out", memory_out, '0);
    chk_word("rst_gpio_out", {10'd0, gpio_out}, '0);
    chk_bit("rst_wake", wake, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    // RAM read-after-write and read-first collision
    wr(18'd5, 18'h2AAAA);
    rd(18'd5, 18'h2AAAA, "ram_raw");
    acc(18'd5, 1'b1, 18'h15555, 1'b1, 18'h2AAAA, -1, "ram_read_first");
    rd(18'd5, 18'h15555, "ram_new");
    wr(18'd0, 18'h00777);
    wr(18'h003FF, 18'h3ABCD);
    rd(18'h003FF, 18'h3ABCD, "ram_top");

    // Hole: writes ignored, reads zero, RAM aliasing absent
    wr(18'h00800, 18'h12345);
    rd(18'h00800, 18'h0, "hole_800");
    rd(18'd0, 18'h00777, "ram0_intact");
    rd(18'h00400, 18'h0, "hole_400");
    rd(18'h3FEFF, 18'h0, "hole_below_io");

    // GPIO out/in and unused offsets
    wr(IO + 18'h3, 18'h3FFA5);
    chk_word("gpio_out_port", {10'd0, gpio_out}, 18'h000A5);
    rd(IO + 18'h3, 18'h000A5, "gpio_out_rd");
    gpio_in = 8'h3C;
    rd(IO + 18'h4, 18'h0, "gpio_in_sync1");
    rd(IO + 18'h4, 18'h0, "gpio_in_sync2");
    rd(IO + 18'h4, 18'h0003C, "gpio_in_sync3");
    wr(IO + 18'h4, 18'h00011);
    rd(IO + 18'h4, 18'h0003C, "gpio_in_ro");
    wr(IO + 18'h5, 18'h3FFFF);
    rd(IO + 18'h5, 18'h0, "io_unused");

    // Timer wake: count 10 -> compare 20
    wr(IO + 18'h1, 18'd20);
    wr(IO + 18'h0, 18'd10);
    wr(IO + 18'h2, 18'h1);
    for (int j = 1; j <= 12; j++) idle((j == 10) ? 1 : 0, "wake_pulse");
    rd(IO + 18'h2, 18'h3, "wake_ctrl_pending");
    wr(IO + 18'h2, 18'h3);
    rd(IO + 18'h2, 18'h1, "wake_ctrl_cleared");

    // Clear-pending write in the match cycle: set wins
    wr(IO + 18'h1, 18'd200);
    wr(IO + 18'h0, 18'd197);
    for (int j = 0; j < 3; j++) idle(0, "clr_pre");
    wr(IO + 18'h2, 18'h3, 1);
    rd(IO + 18'h2, 18'h3, "clr_vs_set");

    // Count write in the match cycle: wake still fires, load wins
    wr(IO + 18'h1, 18'd300);
    wr(IO + 18'h0, 18'd297);
    for (int j = 0; j < 3; j++) idle(0, "cntwr_pre");
    wr(IO + 18'h0, 18'd500, 1);
    rd(IO + 18'h0, 18'd500, "cntwr_load", 0);

    // Wrap through 2^18-1 with compare 0
    wr(IO + 18'h1, 18'd0);
    wr(IO + 18'h0, 18'h3FFFE);
    rd(IO + 18'h0, 18'h3FFFE, "wrap_a", 0);
    rd(IO + 18'h0, 18'h3FFFF, "wrap_b", 0);
    rd(IO + 18'h0, 18'h00000, "wrap_c", 1);
    idle(0, "wrap_after");

    // Asynchronous reset mid-run
    wr(IO + 18'h3, 18'h000A5);
    rd(IO + 18'h2, 18'h3, "pre_rst_pending");
    rd(18'd5, 18'h15555, "pre_rst_ram");
    #2 reset = 1'b0;
    #1;
    chk_word("arst_memory_out", memory_out, '0);
    chk_word("arst_gpio_out", {10'd0, gpio_out}, '0);
    chk_bit("arst_wake", wake, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    rd(IO + 18'h0, 18'h0, "post_rst_count");
    rd(IO + 18'h1, 18'h0, "post_rst_compare");
    rd(IO + 18'h2, 18'h0, "post_rst_wake_ctrl");
    rd(IO + 18'h3, 18'h0, "post_rst_gpio");
    rd(18'd5, 18'h15555, "post_rst_ram5");
    rd(18'd0, 18'h00777, "post_rst_ram0");
    chk_word("post_rst_queue_empty", 18'(exp_q.size()), 18'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
